ky32_dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single data-memory port between the KY32 CPU load/store path (port 0) and the debug/program-loader master (port 1). It applies round-robin arbitration with an optional locked burst for the loader, and drives the memory address, write-data and write-enable lines. It returns registered read data with a valid strobe and produces a CPU stall when port 0 is refused. It sits between the CPU, the loader and the data memory at the top level.

---
 rtl/ky32_pkg.sv | 14 +
 rtl/ky32_rr_pick.sv | 30 +++
 rtl/ky32_dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_ky32_dmem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ky32_pkg.sv
// Shared KY32 data-memory arbitration types: ownership states, port indices, burst default.
package ky32_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P0   = 2'd1,
    P1   = 2'd2
  } owner_t;

  localparam int PORT_CPU      = 0;
  localparam int PORT_LDR      = 1;
  localparam int MAX_BURST_DEF = 8;

endpackage

// File: rtl/ky32_rr_pick.sv
// Two-way round-robin picker with a loader lock override; returns a one-hot (or zero) grant vector.
module ky32_rr_pick
  import ky32_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lock1,
  input  logic       owner_p1,
  input  logic       burst_open,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[PORT_CPU] && !req[PORT_LDR]) begin
      gnt[PORT_CPU] = 1'b1;
    end else if (req[PORT_LDR] && !req[PORT_CPU]) begin
      gnt[PORT_LDR] = 1'b1;
    end else if (req[PORT_CPU] && req[PORT_LDR]) begin
      // Locked loader keeps the port until its burst budget is spent
      if (owner_p1 && lock1 && burst_open)
        gnt[PORT_LDR] = 1'b1;
      else if (last)
        gnt[PORT_CPU] = 1'b1;
      else
        gnt[PORT_LDR] = 1'b1;
    end
  end

endmodule

// File: rtl/ky32_dmem_arbiter.sv
// Shares the data-memory port between the CPU (port 0) and the loader (port 1);
// zero-latency grant, registered read return, CPU stall on refusal.
module ky32_dmem_arbiter
  import ky32_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int AW        = 32,
  parameter int DW        = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          stall0,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  owner_t        owner_q, owner_d;
  logic          last_q, last_d;
  logic [7:0]    burst_q, burst_d;
  logic [1:0]    pick_gnt, gnt;
  logic          rd_gnt;
  logic [AW-1:0] addr_hold_q;
  logic [DW-1:0] wdata_hold_q;
  logic          rd_vld0_p1, rd_vld1_p1;
  logic [DW-1:0] rdata_p1;

  ky32_rr_pick u_pick (
    .req        ({req1, req0}),
    .lock1      (lock1),
    .owner_p1   (owner_q == P1),
    .burst_open (burst_q < BURST_MAX),
    .last       (last_q),
    .gnt        (pick_gnt)
  );

  // Stage p0: grant and memory mux, suppressed while reset is asserted
  assign gnt    = rst ? 2'b00 : pick_gnt;
  assign gnt0   = gnt[PORT_CPU];
  assign gnt1   = gnt[PORT_LDR];
  assign stall0 = req0 & ~gnt0;
  assign mem_we = (gnt0 & we0) | (gnt1 & we1);
  assign rd_gnt = (gnt0 & ~we0) | (gnt1 & ~we1);

  always_comb begin
    mem_addr  = addr_hold_q;
    mem_wdata = wdata_hold_q;
    if (gnt0) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  always_comb begin
    owner_d = IDLE;
    last_d  = last_q;
    burst_d = 8'd0;
    if (gnt0) begin
      owner_d = P0;
      last_d  = 1'b0;
    end else if (gnt1) begin
      owner_d = P1;
      last_d  = 1'b1;
      if (owner_q != P1)
        burst_d = 8'd1;
      else if (burst_q >= BURST_MAX)
        burst_d = burst_q;
      else
        burst_d = burst_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= IDLE;
      last_q     <= 1'b1;
      burst_q    <= 8'd0;
      rd_vld0_p1 <= 1'b0;
      rd_vld1_p1 <= 1'b0;
      rdata_p1   <= '0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      burst_q    <= burst_d;
      rd_vld0_p1 <= gnt0 & ~we0;
      rd_vld1_p1 <= gnt1 & ~we1;
      if (rd_gnt)
        rdata_p1 <= mem_rdata;
    end
  end

  // Idle cycles keep presenting the last granted address and data
  always_ff @(posedge clk) begin
    if (gnt0 || gnt1) begin
      addr_hold_q  <= mem_addr;
      wdata_hold_q <= mem_wdata;
    end
  end

  // Stage p1: registered read return
  assign rvalid0 = rd_vld0_p1;
  assign rvalid1 = rd_vld1_p1;
  assign rdata   = rdata_p1;

endmodule

// File: tb/tb_ky32_dmem_arbiter.sv
// Directed bench for ky32_dmem_arbiter with a small word-addressed memory model.
module tb_ky32_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, req0, req1, we0, we1, lock1;
  logic [AW-1:0] addr0, addr1, mem_addr;
  logic [DW-1:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;
  logic          gnt0, gnt1, rvalid0, rvalid1, stall0, mem_we;
  logic [DW-1:0] mem [0:255];
  int            tests_run = 0;
  int            fails = 0;

  ky32_dmem_arbiter #(.MAX_BURST(8), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .stall0(stall0), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock1 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    #1;
    tests_run++;
    if ({gnt0, gnt1, mem_we, stall0} !== 4'b0001) begin
      fails++;
      $display("FAIL reset_gnt: got gnt0/gnt1/mem_we/stall0=%b want 0001", {gnt0, gnt1, mem_we, stall0});
    end
    tests_run++;
    if ({rvalid0, rvalid1} !== 2'b00 || rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_regs: got rvalid=%b rdata=%h want 00 00000000", {rvalid0, rvalid1}, rdata);
    end
    idle();
    step();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    #1;
    tests_run++;
    if ({gnt0, gnt1, stall0, mem_we} !== 4'b1000 || mem_addr !== 32'h10) begin
      fails++;
      $display("FAIL single_read_gnt: got g/s/we=%b addr=%h want 1000 00000010", {gnt0, gnt1, stall0, mem_we}, mem_addr);
    end
    step();
    idle();
    tests_run++;
    if ({rvalid0, rvalid1} !== 2'b10 || rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL single_read_data: got rvalid=%b rdata=%h want 10 deadbeef", {rvalid0, rvalid1}, rdata);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_seq [4];
    exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01};
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h14;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if ({gnt0, gnt1} !== exp_seq[i] || stall0 !== exp_seq[i][0]) begin
        fails++;
        $display("FAIL alternate_%0d: got gnt=%b stall0=%b want %b %b", i, {gnt0, gnt1}, stall0, exp_seq[i], exp_seq[i][0]);
      end
      step();
      tests_run++;
      if ({rvalid0, rvalid1} !== exp_seq[i]) begin
        fails++;
        $display("FAIL alternate_rvalid_%0d: got %b want %b", i, {rvalid0, rvalid1}, exp_seq[i]);
      end
    end
    idle();
  endtask

  // Tie first (port 0 wins), then 8 locked loader writes, then port 0 again
  task automatic run_tie_burst(input string name);
    int  k;
    logic e;
    k = 0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    req1 = 1'b1; we1 = 1'b1; lock1 = 1'b1; addr1 = 32'h100; wdata1 = 32'h1000_0000;
    for (int i = 0; i < 10; i++) begin
      e = (i >= 1 && i <= 8);
      #1;
      tests_run++;
      if ({gnt0, gnt1, stall0} !== {~e, e, e} || (e && (mem_we !== 1'b1 || mem_addr !== addr1))) begin
        fails++;
        $display("FAIL %s_%0d: got g0/g1/stall=%b we=%b addr=%h want %b", name, i, {gnt0, gnt1, stall0}, mem_we, mem_addr, {~e, e, e});
      end
      step();
      if (e) begin
        k++;
        addr1 = 32'h100 + 32'(4 * k);
        wdata1 = 32'h1000_0000 + 32'(k);
      end
    end
    idle();
  endtask

  task automatic test_lock_tie();
    do_reset();
    mem[64] = 32'h0; mem[71] = 32'h0;
    run_tie_burst("lock_tie");
    tests_run++;
    if (mem[64] !== 32'h1000_0000 || mem[71] !== 32'h1000_0007) begin
      fails++;
      $display("FAIL lock_tie_mem: got %h %h want 10000000 10000007", mem[64], mem[71]);
    end
  endtask

  task automatic test_lock_owned();
    logic e;
    do_reset();
    req1 = 1'b1; we1 = 1'b1; lock1 = 1'b1; addr1 = 32'h180; wdata1 = 32'h55;
    for (int i = 0; i < 10; i++) begin
      #1;
      tests_run++;
      if ({gnt0, gnt1, stall0} !== 3'b010) begin
        fails++;
        $display("FAIL lock_solo_%0d: got %b want 010", i, {gnt0, gnt1, stall0});
      end
      step();
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    #1;
    tests_run++;
    if ({gnt0, gnt1, stall0} !== 3'b100) begin
      fails++;
      $display("FAIL lock_saturated: got %b want 100", {gnt0, gnt1, stall0});
    end
    step();
    req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if ({gnt0, gnt1, stall0} !== 3'b010) begin
        fails++;
        $display("FAIL lock_own_solo_%0d: got %b want 010", i, {gnt0, gnt1, stall0});
      end
      step();
    end
    req0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e = (i < 5);
      #1;
      tests_run++;
      if ({gnt0, gnt1, stall0} !== {~e, e, e}) begin
        fails++;
        $display("FAIL lock_owned_%0d: got %b want %b", i, {gnt0, gnt1, stall0}, {~e, e, e});
      end
      step();
    end
    idle();
  endtask

  task automatic test_lock_release();
    logic [4:0] exp_g1;
    exp_g1 = 5'b10110;
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    req1 = 1'b1; we1 = 1'b1; lock1 = 1'b1; addr1 = 32'h180; wdata1 = 32'h66;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) lock1 = 1'b0;
      #1;
      tests_run++;
      if ({gnt0, gnt1} !== {~exp_g1[i], exp_g1[i]}) begin
        fails++;
        $display("FAIL lock_release_%0d: got gnt=%b want %b", i, {gnt0, gnt1}, {~exp_g1[i], exp_g1[i]});
      end
      step();
    end
    idle();
  endtask

  task automatic test_write_read();
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wdata1 = 32'hA5A5A5A5;
    #1;
    tests_run++;
    if ({gnt0, gnt1, mem_we} !== 3'b011 || mem_addr !== 32'h40 || mem_wdata !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL write_beat: got g/we=%b addr=%h wdata=%h want 011 00000040 a5a5a5a5", {gnt0, gnt1, mem_we}, mem_addr, mem_wdata);
    end
    step();
    idle();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
    #1;
    tests_run++;
    if ({gnt0, gnt1, mem_we} !== 3'b100) begin
      fails++;
      $display("FAIL read_back_gnt: got %b want 100", {gnt0, gnt1, mem_we});
    end
    step();
    idle();
    tests_run++;
    if (rdata !== 32'hA5A5A5A5 || {rvalid0, rvalid1} !== 2'b10) begin
      fails++;
      $display("FAIL read_back_data: got rdata=%h rvalid=%b want a5a5a5a5 10", rdata, {rvalid0, rvalid1});
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    req1 = 1'b1; we1 = 1'b1; lock1 = 1'b1; addr1 = 32'h180; wdata1 = 32'h77;
    step(); step(); step();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if ({gnt0, gnt1, mem_we, stall0} !== 4'b0001) begin
        fails++;
        $display("FAIL mid_reset_%0d: got g0/g1/we/stall=%b want 0001", i, {gnt0, gnt1, mem_we, stall0});
      end
      step();
    end
    rst = 1'b0;
    run_tie_burst("post_reset");
  endtask

  task automatic test_idle_hold();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    step();
    idle();
    tests_run++;
    if (rvalid0 !== 1'b1 || rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL idle_first_read: got rvalid0=%b rdata=%h want 1 deadbeef", rvalid0, rdata);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if ({rvalid0, rvalid1, mem_we} !== 3'b000 || rdata !== 32'hDEADBEEF || mem_addr !== 32'h10) begin
        fails++;
        $display("FAIL idle_hold_%0d: got rv/we=%b rdata=%h addr=%h want 000 deadbeef 00000010", i, {rvalid0, rvalid1, mem_we}, rdata, mem_addr);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[4] = 32'hDEADBEEF;
    step();
    step();
    test_reset();
    test_single_read();
    test_alternate();
    test_lock_tie();
    test_lock_owned();
    test_lock_release();
    test_write_read();
    test_reset_mid_burst();
    test_idle_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
